weighted_product_collector: RTL and testbench
=============================================

# weighted_product_collector

Upstream feeder for the popcount/accumulation stage. It streams unsigned activations in lane-wide beats and applies one latched binary weight (+1/-1) per input. It assembles the full PARAM_IN_CNT-element vector of signed (PARAM_IN_BIT+1)-bit products. It then holds that vector stable under a valid/ready handshake until the downstream accumulator takes it.

## Interface
- PARAM_IN_CNT, 784: elements per frame; must be a multiple of PARAM_LANE_CNT.
- PARAM_IN_BIT, 2: activation width (unsigned); product width is PARAM_IN_BIT+1.
- PARAM_LANE_CNT, 16: activations accepted per beat.
- Derived, not overridable:
  - BEATS = PARAM_IN_CNT/PARAM_LANE_CNT.
  - Beat counter width = max(1, $clog2(BEATS)).
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start_i  in  1  begin a frame; latches weight_i; honoured only as stated under Operation.
- flush_i  in  1  synchronous abort to IDLE.
- weight_i  in  [PARAM_IN_CNT-1:0]  1 = +1, 0 = -1; sampled only on an accepted start.
- act_valid_i  in  1  activation beat valid.
- act_ready_o  out  1  activation beat ready.
- act_data_i  in  [PARAM_LANE_CNT-1:0][PARAM_IN_BIT-1:0]  lane j of beat b is element b*PARAM_LANE_CNT+j.
- product_o  out  [PARAM_IN_CNT-1:0][PARAM_IN_BIT:0]  signed products, registered.
- product_valid_o  out  1  product_o complete and stable.
- product_ready_i  in  1  downstream consumes the vector.
- busy_o  out  1  state != IDLE.

## Operation
- FSM states: IDLE, COLLECT, HOLD.
- IDLE
  - act_ready_o=0 and product_valid_o=0.
  - When start_i=1 (and flush_i=0): latch weight_i, clear the beat counter, go to COLLECT.
- COLLECT
  - act_ready_o = !flush_i (combinational).
  - A beat is accepted when act_valid_i && act_ready_o. On acceptance:
    - Write PARAM_LANE_CNT products into slots counter*PARAM_LANE_CNT .. +PARAM_LANE_CNT-1.
    - Increment the counter.
  - Acceptance at counter == BEATS-1 moves the FSM to HOLD and resets the counter to 0.
  - start_i is ignored.
- HOLD
  - product_valid_o=1; act_ready_o=0; product_o must not change.
  - product_ready_i=1 ends the hold:
    - If start_i=1 in the same cycle: relatch weights and go directly to COLLECT (back-to-back frames).
    - Otherwise: go to IDLE.
  - start_i without product_ready_i is ignored.
- Product arithmetic, per element a (unsigned, PARAM_IN_BIT bits) with weight w:
  - w=1: product = {1'b0, a}.
  - w=0: product = 0 - {1'b0, a}, two's complement in PARAM_IN_BIT+1 bits.
  - Range is ±(2^PARAM_IN_BIT-1); no overflow is possible, and a=0 gives 0 for either weight.
- flush_i has priority over every other input in every state:
  - Next state IDLE, counter cleared.
  - The beat in the flush cycle is not accepted.
  - product_o retains its contents but product_valid_o drops.
- Partially written vectors are never presented. Slots not rewritten since the last frame keep old values, which is harmless because valid is asserted only after all BEATS writes.

## Timing
- Reset (rst_n=0, asynchronous) drives:
  - State IDLE; counter 0; latched weights 0.
  - product_o all zeros.
  - act_ready_o=0, product_valid_o=0, busy_o=0.
- Release of reset is synchronised by the integrator; first start is honoured on any edge after deassertion.
- start accepted at edge T0: act_ready_o=1 and busy_o=1 from T0 onward.
- Last beat accepted at edge Tn: product_valid_o=1 from Tn onward; registered, 1-cycle latency.
- Handshake at edge Th (valid && ready):
  - product_valid_o=0 after Th, unless start_i was also high, in which case act_ready_o=1 after Th.
- Minimum frame period with continuous act_valid_i: BEATS+1 cycles (BEATS beats plus one HOLD cycle when product_ready_i is tied high).
- act_valid_i may stall between beats indefinitely; the counter holds.
- product_ready_i may stall indefinitely; product_o holds.

## Test plan
- Sign mapping
  - Stimulus: IN_CNT=784, LANE=16; all weights 1; 49 beats with every lane = 3.
  - Required: product_valid_o=1 one cycle after beat 49; every product_o element = 3'b011.
- Negative products and ordering
  - Stimulus: weight[i] = i[0]; activation[i] = i mod 4.
  - Required: element 5 = 3'b001, element 6 = 3'b110 (-2), element 7 = 3'b011, element 4 = 3'b000.
- Beat and downstream stalls
  - Stimulus: act_valid_i toggles every other cycle; product_ready_i held 0 for 10 cycles after valid.
  - Required: exactly 49 beats accepted; act_ready_o=0 throughout HOLD; product_o unchanged for all 10 cycles.
- Back-to-back frames
  - Stimulus: start_i=1 in the same cycle as the product handshake; second frame uses all weights 0 and activations = 1.
  - Required: act_ready_o=1 on the very next cycle; second vector all 3'b111.
- Flush mid-frame
  - Stimulus: flush_i on beat 20 with act_valid_i=1.
  - Required: that beat is not accepted; state IDLE next cycle, busy_o=0; a fresh frame needs a full 49 beats before valid.
- Asynchronous reset in HOLD
  - Stimulus: drive rst_n low between clock edges while in HOLD.
  - Required: product_valid_o and busy_o drop immediately without waiting for a clock edge; product_o all zeros.

Source files
------------

// File: rtl/weighted_product_collector.sv
// weighted_product_collector
// Streams unsigned activations in lane-wide beats, multiplies each by a
// latched binary weight (+1/-1), assembles the full product vector and
// holds it under a valid/ready handshake until the accumulator takes it.
module weighted_product_collector #(
   parameter int PARAM_IN_CNT   = 784,
   parameter int PARAM_IN_BIT   = 2,
   parameter int PARAM_LANE_CNT = 16
) (
   input  logic                                         clk,
   input  logic                                         rst_n,
   input  logic                                         start_i,
   input  logic                                         flush_i,
   input  logic [PARAM_IN_CNT-1:0]                      weight_i,
   input  logic                                         act_valid_i,
   output logic                                         act_ready_o,
   input  logic [PARAM_LANE_CNT-1:0][PARAM_IN_BIT-1:0]  act_data_i,
   output logic [PARAM_IN_CNT-1:0][PARAM_IN_BIT:0]      product_o,
   output logic                                         product_valid_o,
   input  logic                                         product_ready_i,
   output logic                                         busy_o
);

   localparam int BEATS = PARAM_IN_CNT / PARAM_LANE_CNT;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int IDX_W = (PARAM_IN_CNT > 1) ? $clog2(PARAM_IN_CNT) : 1;
   localparam int P_W   = PARAM_IN_BIT + 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_HOLD    = 2'd2
   } state_t;

   state_t                                state_q, state_d;
   logic [CNT_W-1:0]                      cnt_q, cnt_d;
   logic [PARAM_IN_CNT-1:0]               weight_q;
   logic                                  load_weight;
   logic [PARAM_IN_CNT-1:0][P_W-1:0]      product_q;

   logic                                  accept;
   logic [IDX_W-1:0]                      base_idx;
   logic [IDX_W-1:0]                      lane_idx  [PARAM_LANE_CNT];
   logic [P_W-1:0]                        lane_prod [PARAM_LANE_CNT];

   // A beat is only taken while collecting and not being flushed.
   assign accept   = (state_q == ST_COLLECT) && act_valid_i && !flush_i;
   assign base_idx = IDX_W'(cnt_q) * IDX_W'(PARAM_LANE_CNT);

   // Per-lane sign application: +a for weight 1, two's-complement -a for weight 0.
   generate
      for (genvar gi = 0; gi < PARAM_LANE_CNT; gi++) begin : g_lane
         logic [P_W-1:0] a_ext;
         assign lane_idx[gi]  = base_idx + IDX_W'(gi);
         assign a_ext         = {1'b0, act_data_i[gi]};
         assign lane_prod[gi] = weight_q[lane_idx[gi]] ? a_ext : (P_W'(0) - a_ext);
      end
   endgenerate

   // State, beat counter and latched weights.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         weight_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (load_weight) begin
            weight_q <= weight_i;
         end
      end
   end

   // Product vector: one lane-wide slice written per accepted beat, otherwise held.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         product_q <= '0;
      end else if (accept) begin
         for (int j = 0; j < PARAM_LANE_CNT; j++) begin
            product_q[lane_idx[j]] <= lane_prod[j];
         end
      end
   end

   // Next-state logic; flush overrides everything and returns to idle.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      load_weight = 1'b0;
      if (flush_i) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (start_i) begin
                  load_weight = 1'b1;
                  cnt_d       = '0;
                  state_d     = ST_COLLECT;
               end
            end
            ST_COLLECT: begin
               if (accept) begin
                  if (cnt_q == CNT_W'(BEATS - 1)) begin
                     cnt_d   = '0;
                     state_d = ST_HOLD;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end
            ST_HOLD: begin
               if (product_ready_i) begin
                  if (start_i) begin
                     load_weight = 1'b1;
                     cnt_d       = '0;
                     state_d     = ST_COLLECT;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   assign act_ready_o     = (state_q == ST_COLLECT) && !flush_i;
   assign product_valid_o = (state_q == ST_HOLD);
   assign busy_o          = (state_q != ST_IDLE);
   assign product_o       = product_q;

endmodule

// File: tb/tb_weighted_product_collector.sv
// Directed testbench for weighted_product_collector.
module tb_weighted_product_collector;

   localparam int IN_CNT = 784;
   localparam int IN_BIT = 2;
   localparam int LANE   = 16;
   localparam int BEATS  = IN_CNT / LANE;
   localparam int VEC_W  = IN_CNT * (IN_BIT + 1);

   logic                            clk = 1'b0;
   logic                            rst_n = 1'b1;
   logic                            start_i = 1'b0;
   logic                            flush_i = 1'b0;
   logic [IN_CNT-1:0]               weight_i = '0;
   logic                            act_valid_i = 1'b0;
   logic                            act_ready_o;
   logic [LANE-1:0][IN_BIT-1:0]     act_data_i = '0;
   logic [IN_CNT-1:0][IN_BIT:0]     product_o;
   logic                            product_valid_o;
   logic                            product_ready_i = 1'b0;
   logic                            busy_o;

   int n_checks = 0;
   int n_errors = 0;
   int beats_acc = 0;
   int beats_snap;

   logic [IN_CNT-1:0][IN_BIT-1:0]   act_frame;
   logic [IN_CNT-1:0][IN_BIT:0]     exp_vec;
   logic [IN_CNT-1:0][IN_BIT:0]     zero_vec;

   weighted_product_collector #(
      .PARAM_IN_CNT   (IN_CNT),
      .PARAM_IN_BIT   (IN_BIT),
      .PARAM_LANE_CNT (LANE)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .start_i         (start_i),
      .flush_i         (flush_i),
      .weight_i        (weight_i),
      .act_valid_i     (act_valid_i),
      .act_ready_o     (act_ready_o),
      .act_data_i      (act_data_i),
      .product_o       (product_o),
      .product_valid_o (product_valid_o),
      .product_ready_i (product_ready_i),
      .busy_o          (busy_o)
   );

   always #5 clk = ~clk;

   // Count accepted activation beats.
   always @(posedge clk) begin
      if (rst_n && act_valid_i && act_ready_o) beats_acc <= beats_acc + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_vec(input string tag, input logic [VEC_W-1:0] obs, input logic [VEC_W-1:0] exp);
      int idx;
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         idx = 0;
         for (int i = IN_CNT - 1; i >= 0; i--) begin
            if (obs[i*3 +: 3] !== exp[i*3 +: 3]) idx = i;
         end
         $error("FAIL %s: element %0d observed %b expected %b", tag, idx, obs[idx*3 +: 3], exp[idx*3 +: 3]);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present beats first..first+n-1 of act_frame; optionally idle one cycle between beats.
   task automatic send_beats(input int first, input int n, input bit gap);
      for (int b = first; b < first + n; b++) begin
         act_valid_i = 1'b1;
         for (int j = 0; j < LANE; j++) act_data_i[j] = act_frame[b*LANE + j];
         tick();
         if (gap) begin
            act_valid_i = 1'b0;
            tick();
         end
      end
      act_valid_i = 1'b0;
   endtask

   // Fill expected vector with one constant 3-bit product.
   task automatic fill_exp(input logic [2:0] v);
      for (int i = 0; i < IN_CNT; i++) exp_vec[i] = v;
   endtask

   initial begin
      zero_vec = '0;

      // Reset
      #2 rst_n = 1'b0;
      #1;
      chk("reset_valid", 32'(product_valid_o), 32'd0);
      chk("reset_busy", 32'(busy_o), 32'd0);
      chk("reset_ready", 32'(act_ready_o), 32'd0);
      chk_vec("reset_product", product_o, zero_vec);
      tick();
      rst_n = 1'b1;
      tick();

      // Frame 1: all weights +1, all activations 3
      weight_i = '1;
      for (int i = 0; i < IN_CNT; i++) act_frame[i] = 2'd3;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      weight_i = '0;
      chk("f1_ready_after_start", 32'(act_ready_o), 32'd1);
      chk("f1_busy_after_start", 32'(busy_o), 32'd1);
      send_beats(0, BEATS - 1, 1'b0);
      chk("f1_valid_before_last", 32'(product_valid_o), 32'd0);
      send_beats(BEATS - 1, 1, 1'b0);
      chk("f1_valid_after_last", 32'(product_valid_o), 32'd1);
      fill_exp(3'b011);
      chk_vec("f1_vector", product_o, exp_vec);
      product_ready_i = 1'b1;
      tick();
      product_ready_i = 1'b0;
      chk("f1_valid_after_hs", 32'(product_valid_o), 32'd0);
      chk("f1_busy_after_hs", 32'(busy_o), 32'd0);
      $display("frame 1 done: all +3");

      // Frame 2: weight[i]=i[0], activation[i]=i mod 4, stalled beats
      for (int i = 0; i < IN_CNT; i++) begin
         weight_i[i]  = 1'(i % 2);
         act_frame[i] = 2'(i % 4);
      end
      for (int i = 0; i < IN_CNT; i += 4) begin
         exp_vec[i]   = 3'b000;
         exp_vec[i+1] = 3'b001;
         exp_vec[i+2] = 3'b110;
         exp_vec[i+3] = 3'b011;
      end
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      weight_i = '0;
      beats_snap = beats_acc;
      send_beats(0, BEATS, 1'b1);
      chk("f2_beats_accepted", 32'(beats_acc - beats_snap), 32'd49);
      chk("f2_valid", 32'(product_valid_o), 32'd1);
      chk("f2_elem4", 32'(product_o[4]), 32'b000);
      chk("f2_elem5", 32'(product_o[5]), 32'b001);
      chk("f2_elem6", 32'(product_o[6]), 32'b110);
      chk("f2_elem7", 32'(product_o[7]), 32'b011);
      chk_vec("f2_vector", product_o, exp_vec);
      for (int c = 0; c < 10; c++) begin
         act_valid_i = 1'b1;
         tick();
         chk("f2_hold_ready_low", 32'(act_ready_o), 32'd0);
         chk("f2_hold_valid", 32'(product_valid_o), 32'd1);
         chk_vec("f2_hold_stable", product_o, exp_vec);
      end
      act_valid_i = 1'b0;
      $display("frame 2 done: alternating signs, stalls");

      // Frame 3: back-to-back start on the handshake, weights -1, activations 1
      weight_i = '0;
      for (int i = 0; i < IN_CNT; i++) act_frame[i] = 2'd1;
      product_ready_i = 1'b1;
      start_i = 1'b1;
      tick();
      product_ready_i = 1'b0;
      start_i = 1'b0;
      chk("f3_ready_next_cycle", 32'(act_ready_o), 32'd1);
      chk("f3_valid_dropped", 32'(product_valid_o), 32'd0);
      send_beats(0, BEATS, 1'b0);
      chk("f3_valid", 32'(product_valid_o), 32'd1);
      fill_exp(3'b111);
      chk_vec("f3_vector", product_o, exp_vec);
      product_ready_i = 1'b1;
      tick();
      product_ready_i = 1'b0;
      chk("f3_busy_after_hs", 32'(busy_o), 32'd0);
      $display("frame 3 done: back-to-back, all -1");

      // Frame 4: flush on beat 20, then a fresh full frame
      weight_i = '1;
      for (int i = 0; i < IN_CNT; i++) act_frame[i] = 2'd2;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      beats_snap = beats_acc;
      send_beats(0, 19, 1'b0);
      act_valid_i = 1'b1;
      for (int j = 0; j < LANE; j++) act_data_i[j] = act_frame[19*LANE + j];
      flush_i = 1'b1;
      #1;
      chk("f4_ready_in_flush", 32'(act_ready_o), 32'd0);
      tick();
      flush_i = 1'b0;
      act_valid_i = 1'b0;
      chk("f4_beats_before_flush", 32'(beats_acc - beats_snap), 32'd19);
      chk("f4_busy_after_flush", 32'(busy_o), 32'd0);
      chk("f4_valid_after_flush", 32'(product_valid_o), 32'd0);
      for (int i = 0; i < 19*LANE; i++) exp_vec[i] = 3'b010;
      chk_vec("f4_partial_retained", product_o, exp_vec);
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      weight_i = '0;
      send_beats(0, BEATS - 1, 1'b0);
      chk("f4_valid_before_full", 32'(product_valid_o), 32'd0);
      send_beats(BEATS - 1, 1, 1'b0);
      chk("f4_valid_after_full", 32'(product_valid_o), 32'd1);
      fill_exp(3'b010);
      chk_vec("f4_vector", product_o, exp_vec);
      $display("frame 4 done: flush then full frame of +2");

      // Asynchronous reset while holding, between clock edges
      #2;
      rst_n = 1'b0;
      #1;
      chk("areset_valid", 32'(product_valid_o), 32'd0);
      chk("areset_busy", 32'(busy_o), 32'd0);
      chk_vec("areset_product", product_o, zero_vec);
      tick();
      rst_n = 1'b1;
      tick();
      $display("async reset in hold done");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
